// File: rtl/msg_framer_mc_if.sv
// Beat stream seen by msg_framer_mc.
// valid qualifies head, tail and ch. There is no ready signal: the framer
// only observes the stream, so a beat counts on every cycle where valid=1.
interface msg_framer_mc_if #(
  parameter int CH_W = 2
) ();
  logic            valid;
  logic            head;
  logic            tail;
  logic [CH_W-1:0] ch;

  modport master (output valid, head, tail, ch);
  modport slave  (input  valid, head, tail, ch);
endinterface

// File: rtl/msg_framer_mc.sv
// msg_framer_mc: per-channel message framer/checker for an interleaved beat
// stream. Each channel runs its own IDLE/HEAD/DATA/TAIL machine and length
// counter. The block reports completed messages (done) and framing errors
// (err), and shows a message-in-progress flag for each channel.
// Optional feature macro: MSG_FRAMER_ERR_CNT_EN adds a saturating 8-bit
// error counter on err_cnt_o.
module msg_framer_mc #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  msg_framer_mc_if.slave      beat_if,
  output logic [NUM_CH-1:0]   msg_ip_o,
  output logic                done_o,
  output logic [CH_W-1:0]     done_ch_o,
  output logic [LEN_W-1:0]    done_len_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [CH_W-1:0]     err_ch_o,
`ifdef MSG_FRAMER_ERR_CNT_EN
  output logic [7:0]          err_cnt_o,
`endif
  output logic [2*NUM_CH-1:0] st_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_DATA = 2'b10,
    ST_TAIL = 2'b11
  } state_t;

  localparam logic [1:0] ERR_ORPHAN   = 2'b01;
  localparam logic [1:0] ERR_DUP_HEAD = 2'b10;
  localparam logic [1:0] ERR_OVERLEN  = 2'b11;

  state_t           st_q  [NUM_CH];
  state_t           st_d  [NUM_CH];
  logic [LEN_W-1:0] len_q [NUM_CH];
  logic [LEN_W-1:0] len_d [NUM_CH];

  logic             done_q, done_d;
  logic [CH_W-1:0]  done_ch_q, done_ch_d;
  logic [LEN_W-1:0] done_len_q, done_len_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CH_W-1:0]  err_ch_q, err_ch_d;
  logic             hit;

  // Next state per channel; at most one channel is addressed per cycle,
  // so at most one done and one err source is active.
  always_comb begin
    done_d     = 1'b0;
    done_ch_d  = done_ch_q;
    done_len_d = done_len_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    err_ch_d   = err_ch_q;
    hit        = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]  = st_q[c];
      len_d[c] = len_q[c];
      hit      = beat_if.valid && (beat_if.ch == CH_W'(c));
      case (st_q[c])
        ST_IDLE, ST_TAIL: begin
          if (!hit) begin
            st_d[c] = ST_IDLE;
          end else if (beat_if.head) begin
            len_d[c] = LEN_W'(1);
            if (beat_if.tail) begin
              st_d[c]    = ST_TAIL;
              done_d     = 1'b1;
              done_ch_d  = CH_W'(c);
              done_len_d = LEN_W'(1);
            end else begin
              st_d[c] = ST_HEAD;
            end
          end else begin
            st_d[c]    = ST_IDLE;
            len_d[c]   = '0;
            err_d      = 1'b1;
            err_code_d = ERR_ORPHAN;
            err_ch_d   = CH_W'(c);
          end
        end
        default: begin // ST_HEAD, ST_DATA
          if (hit && beat_if.head) begin
            // Drop the open message and restart from this head beat.
            err_d      = 1'b1;
            err_code_d = ERR_DUP_HEAD;
            err_ch_d   = CH_W'(c);
            len_d[c]   = LEN_W'(1);
            if (beat_if.tail) begin
              st_d[c]    = ST_TAIL;
              done_d     = 1'b1;
              done_ch_d  = CH_W'(c);
              done_len_d = LEN_W'(1);
            end else begin
              st_d[c] = ST_HEAD;
            end
          end else if (hit) begin
            if (len_q[c] == LEN_W'(MAX_LEN)) begin
              // This beat would be number MAX_LEN+1.
              st_d[c]    = ST_IDLE;
              len_d[c]   = '0;
              err_d      = 1'b1;
              err_code_d = ERR_OVERLEN;
              err_ch_d   = CH_W'(c);
            end else begin
              len_d[c] = len_q[c] + LEN_W'(1);
              if (beat_if.tail) begin
                st_d[c]    = ST_TAIL;
                done_d     = 1'b1;
                done_ch_d  = CH_W'(c);
                done_len_d = len_q[c] + LEN_W'(1);
              end else begin
                st_d[c] = ST_DATA;
              end
            end
          end
        end
      endcase
    end
  end

  // State, length and report registers; reset dominates any beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]  <= ST_IDLE;
        len_q[c] <= '0;
      end
      done_q     <= 1'b0;
      done_ch_q  <= '0;
      done_len_q <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      err_ch_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]  <= st_d[c];
        len_q[c] <= len_d[c];
      end
      done_q     <= done_d;
      done_ch_q  <= done_ch_d;
      done_len_q <= done_len_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_ch_q   <= err_ch_d;
    end
  end

`ifdef MSG_FRAMER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of err pulses, aligned with err_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  // Per-channel in-progress flags and packed state view.
  always_comb begin
    msg_ip_o = '0;
    st_dbg_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      msg_ip_o[c]         = (st_q[c] != ST_IDLE);
      st_dbg_o[2*c +: 2]  = st_q[c];
    end
  end

  assign done_o     = done_q;
  assign done_ch_o  = done_ch_q;
  assign done_len_o = done_len_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_ch_o   = err_ch_q;

endmodule

// File: doc/msg_framer_mc.md
# msg_framer_mc

Multi-channel message framer and checker for beat streams carrying head/tail/valid qualifiers. It tracks one IDLE/HEAD/DATA/TAIL state machine per channel, with beats from different channels freely interleaved. It counts message length, reports completed messages and framing errors, and drives a per-channel message-in-progress flag. It sits between the link receive path and downstream message consumers; it observes the stream and never back-pressures it.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- CH_W, 2, channel-id width; 2**CH_W >= NUM_CH
- MAX_LEN, 16, maximum legal message length in beats, head and tail included (>= 1)
- LEN_W, 5, length counter width; 2**LEN_W > MAX_LEN
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- valid  in  1  beat present this cycle
- head  in  1  beat is first of a message (qualified by valid)
- tail  in  1  beat is last of a message (qualified by valid)
- ch  in  CH_W  channel of the beat; values >= NUM_CH are ignored
- msg_ip  out  NUM_CH  per-channel message in progress (state != IDLE)
- done  out  1  one-cycle pulse: message completed
- done_ch  out  CH_W  channel of completed message
- done_len  out  LEN_W  length of completed message in beats
- err  out  1  one-cycle pulse: framing error
- err_code  out  2  01 ORPHAN, 10 DUP_HEAD, 11 OVERLEN
- err_ch  out  CH_W  channel of the error

## Operation
- Per-channel state uses a 2-bit encoding: IDLE=00, HEAD=01, DATA=10, TAIL=11. Each channel also has a LEN_W length counter.
- A beat is addressed to channel c when valid=1 and ch==c. Only the addressed channel changes state on a beat. Every other channel in TAIL moves to IDLE; channels in other states hold.
- IDLE or TAIL, beat:
  - head&!tail -> HEAD, len=1.
  - head&tail -> TAIL, len=1, done with len 1.
  - !head -> ORPHAN error; the beat is dropped and the channel goes to IDLE.
- TAIL, no beat on this channel -> IDLE.
- HEAD or DATA, beat:
  - !head&!tail -> DATA, len+1.
  - !head&tail -> TAIL, done with len+1.
  - head -> DUP_HEAD error. The open message is discarded and the beat restarts a new message: HEAD, len=1. If tail is also set, the channel goes to TAIL and done is reported with len 1 in the same cycle as the error.
- HEAD or DATA, no beat -> hold.
- Overlength check: a non-head beat that would make len = MAX_LEN+1 raises an OVERLEN error. The message is discarded, the channel goes to IDLE, and no done is reported. A tail arriving exactly at len = MAX_LEN is legal.
- Beats with ch >= NUM_CH have no effect on any channel.
- done_ch, done_len, err_ch and err_code hold their last values while their strobe is low.

## Timing
- All outputs are registered. State, msg_ip, done and err update on the rising edge that samples the beat, so they are visible one cycle after the beat is presented.
- done and err are single-cycle pulses. They may assert in the same cycle only for a DUP_HEAD beat that also carries tail.
- Back-to-back messages need no gap: a head beat on a channel in TAIL is accepted in the next cycle.
- Reset is synchronous and dominant over beats. On the first edge with reset=1:
  - all channels go to IDLE with len=0;
  - msg_ip=0, done=0, err=0, done_ch=0, done_len=0, err_ch=0, err_code=0.
- Reset mid-message discards the open message and produces no done or err.

## Configuration
- MSG_FRAMER_ERR_CNT_EN defined: the block adds output err_cnt (8 bits). It counts err pulses of all codes, saturates at 255, is cleared by reset, and updates in the same cycle as err.
- MSG_FRAMER_ERR_CNT_EN undefined: no err_cnt port and no counter logic. All other behaviour is identical.

## Test plan
- Single-channel message: after reset, send on ch0 the beats head, data, tail in 3 consecutive cycles -> msg_ip[0]=1 for 3 cycles, then 0; done=1 one cycle after the tail with done_ch=0, done_len=3; err stays 0.
- Interleaved channels: ch1 head, ch2 head, ch1 tail, ch2 data, ch2 tail -> done with (ch1, len 2), then done with (ch2, len 3); msg_ip[1] and msg_ip[2] each 1 from one cycle after their head until one cycle after their tail (inclusive).
- Single-beat message: head&tail on ch3 -> done_len=1, msg_ip[3]=1 for exactly 1 cycle.
- Errors:
  - data beat on idle ch0 -> err=1, err_code=01, msg_ip[0] stays 0;
  - ch0 head, then head again -> err_code=10, done=0, and a following tail gives done_len=2.
- Overlength with MAX_LEN=4:
  - head plus 3 data beats, then tail -> err_code=11, no done, msg_ip[0]=0;
  - head plus 2 data beats, then tail -> done_len=4.
- Reset and counter: assert reset after head+data on ch2 -> no done/err, msg_ip=0 on the next cycle. With MSG_FRAMER_ERR_CNT_EN, 260 orphan beats -> err_cnt=255.
